// File: rtl/vc_shiftregisters_pkg.sv
// Shared types and helpers for the vc_shiftregisters family.
package vc_shiftregisters_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_t;

  // Width needed to hold an element count in 0..n.
  function automatic int unsigned sr_cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vc_piso_datapath.sv
// Latched parallel word and element-select mux for the PISO shift register.
module vc_piso_datapath
  import vc_shiftregisters_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_ELEMENTS = 8,
  parameter int unsigned CNT_W        = sr_cnt_w(NUM_ELEMENTS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_load,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] i_word,
  input  logic [CNT_W-1:0]                   i_sel,
  input  logic                               i_en,
  output logic [DATA_WIDTH-1:0]              o_data
);

  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] r_word;
  logic [DATA_WIDTH-1:0]              w_elem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_word;
    end
  end

  // Select element i_sel; output is forced to zero when no beat is valid.
  always_comb begin
    w_elem = '0;
    for (int unsigned i = 0; i < NUM_ELEMENTS; i++) begin
      if (i_sel == CNT_W'(i)) begin
        w_elem = r_word[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_data = i_en ? w_elem : '0;

endmodule

// File: rtl/vc_shiftregisters_1d_piso.sv
// Parallel-in, serial-out shift register: emits a latched word highest index first.
module vc_shiftregisters_1d_piso
  import vc_shiftregisters_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 32,
  parameter  int unsigned NUM_ELEMENTS = 8,
  localparam int unsigned CNT_W        = sr_cnt_w(NUM_ELEMENTS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_val,
  output logic                               in_rdy,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] in_data,
  input  logic [CNT_W-1:0]                   in_count,
  output logic                               out_val,
  input  logic                               out_rdy,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_last
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_ELEMENTS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  piso_state_t      r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_eff_count;
  logic [CNT_W-1:0] w_sel;
  logic             w_last;
  logic             w_load_fire;
  logic             w_out_fire;

  assign w_eff_count = (in_count > MAX_CNT) ? MAX_CNT : in_count;
  assign w_last      = (r_state == PISO_SHIFT) && (r_remaining == ONE_CNT);
  assign w_sel       = r_remaining - ONE_CNT;

  assign out_val  = (r_state == PISO_SHIFT);
  assign out_last = w_last;
  // Accept a new word while idle, or in the cycle the final element drains.
  assign in_rdy   = (r_state == PISO_IDLE) || (w_last && out_rdy);

  assign w_load_fire = in_val && in_rdy;
  assign w_out_fire  = out_val && out_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= PISO_IDLE;
      r_remaining <= '0;
    end else if (w_load_fire) begin
      r_remaining <= w_eff_count;
      r_state     <= (w_eff_count == '0) ? PISO_IDLE : PISO_SHIFT;
    end else if (w_out_fire) begin
      r_remaining <= r_remaining - ONE_CNT;
      if (r_remaining == ONE_CNT) begin
        r_state <= PISO_IDLE;
      end
    end
  end

  vc_piso_datapath #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_ELEMENTS(NUM_ELEMENTS),
    .CNT_W       (CNT_W)
  ) u_datapath (
    .clk   (clk),
    .reset (reset),
    .i_load(w_load_fire),
    .i_word(in_data),
    .i_sel (w_sel),
    .i_en  (out_val),
    .o_data(out_data)
  );

endmodule
